// File: rtl/petris_pkg.sv
// Shared Petris board geometry, cell/bus types and the cell-index helper.
// Cell (x,y) lives at flat index x*BOARD_H+y; each cell holds a 3-bit {R,G,B} value.
package petris_pkg;

  localparam int unsigned BOARD_W  = 10;
  localparam int unsigned BOARD_H  = 20;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned CELLS    = BOARD_W * BOARD_H;
  localparam int unsigned FRAME_W  = CELLS * COLOR_W;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned FRAME_AW = $clog2(FRAME_W);

  typedef logic [2:0]          color_t;
  typedef logic [3:0]          board_x_t;
  typedef logic [4:0]          board_y_t;
  typedef logic [IDX_W-1:0]    cell_idx_t;
  typedef logic [FRAME_AW-1:0] frame_base_t;

  // One write request as seen by the storage after arbitration.
  typedef struct packed {
    board_x_t x;
    board_y_t y;
    color_t   color;
  } wr_req_t;

  // Flat cell index; only meaningful for in-range coordinates.
  function automatic cell_idx_t idx(input board_x_t x, input board_y_t y);
    return cell_idx_t'(x) * cell_idx_t'(BOARD_H) + cell_idx_t'(y);
  endfunction

  function automatic logic in_range(input board_x_t x, input board_y_t y);
    return (x < board_x_t'(BOARD_W)) && (y < board_y_t'(BOARD_H));
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
// Ports: clock/reset (sync, active-high); req[1:0] requests; advance marks a
// completed transfer for the current grant; grant[1:0] is one-hot or zero.
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio_q = 1: requester 1 wins the next tie; reset favours requester 0.
  logic prio_q, prio_d;

  // Grant selection
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the other requester only when a transfer completes.
  always_comb begin
    prio_d = prio_q;
    if (advance && (grant != 2'b00)) begin
      prio_d = grant[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Petris board storage with vblank-gated, round-robin shared write access and
// a full-board clear sweep.
// Ports: clock/reset (sync, active-high); vblank; two write requesters
// (reqN_valid/x/y/color in, reqN_ready out, combinational); clear_start pulse in,
// clear_busy out; wr_error pulse for accepted out-of-range writes; frame is the
// registered flat board, cell (x,y) at [COLOR_W*(x*BOARD_H+y) +: COLOR_W].
module frame_write_arbiter
  import petris_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               vblank,
  input  logic               req0_valid,
  input  logic [3:0]         req0_x,
  input  logic [4:0]         req0_y,
  input  logic [2:0]         req0_color,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [3:0]         req1_x,
  input  logic [4:0]         req1_y,
  input  logic [2:0]         req1_color,
  output logic               req1_ready,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               wr_error,
  output logic [FRAME_W-1:0] frame
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]         state_q, state_d;
  cell_idx_t          clr_idx_q, clr_idx_d;
  logic               clear_busy_q, clear_busy_d;
  logic               clear_done_q, clear_done_d;
  logic               wr_error_q, wr_error_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic [1:0]  grant;
  logic        can_write;
  logic        advance;
  wr_req_t     wr_sel;
  frame_base_t wr_base;
  frame_base_t clr_base;

  rr_arbiter_2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  // Writes only land in vblank, outside any clear, and never while in reset.
  assign can_write  = vblank && !clear_busy_q && (state_q == ST_IDLE) && !reset;
  assign req0_ready = can_write && req0_valid && grant[0];
  assign req1_ready = can_write && req1_valid && grant[1];
  assign advance    = req0_ready || req1_ready;

  assign wr_sel   = req1_ready ? wr_req_t'({req1_x, req1_y, req1_color})
                               : wr_req_t'({req0_x, req0_y, req0_color});
  assign wr_base  = frame_base_t'(idx(wr_sel.x, wr_sel.y)) * frame_base_t'(COLOR_W);
  assign clr_base = frame_base_t'(clr_idx_q) * frame_base_t'(COLOR_W);

  // Next-state, storage update and clear sequencing
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    wr_error_d   = 1'b0;
    frame_d      = frame_q;

    if (advance) begin
      if (in_range(wr_sel.x, wr_sel.y)) begin
        frame_d[wr_base +: COLOR_W] = wr_sel.color;
      end else begin
        wr_error_d = 1'b1;
      end
    end

    // clear_busy stays up for one IDLE cycle after the sweep ends.
    if (clear_done_q) begin
      clear_busy_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (clear_start && !clear_busy_q) begin
          clear_busy_d = 1'b1;
        end
        // clear_done_q blocks re-entry during the trailing busy cycle.
        if (vblank && clear_busy_q && !clear_done_q) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        if (vblank) begin
          frame_d[clr_base +: COLOR_W] = '0;
          if (clr_idx_q == cell_idx_t'(CELLS - 1)) begin
            state_d      = ST_IDLE;
            clear_done_d = 1'b1;
          end else begin
            clr_idx_d = clr_idx_q + cell_idx_t'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clr_idx_q    <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      wr_error_q   <= 1'b0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      wr_error_q   <= wr_error_d;
      frame_q      <= frame_d;
    end
  end

  assign clear_busy = clear_busy_q;
  assign wr_error   = wr_error_q;
  assign frame      = frame_q;

endmodule
